sram_initiator: RTL and testbench

Request-side master for the single-port SRAM bridge interface (read/r_addr/r_data, write/w_addr/w_data/w_strb). It accepts one load or store at a time from the core LSU over a valid/ready request channel and issues exactly one SRAM read or write. For loads, it captures the one-cycle-latency read data, extracts it and sign- or zero-extends it, then returns the result on a valid/ready response channel. It sits between the LSU and the SRAM bridge, and it is the only block that drives the bridge's command ports.

---
 rtl/sram_init_pkg.sv | 34 +++
 rtl/sram_load_fmt.sv | 27 ++
 rtl/sram_initiator.sv | 115 +++++++++++
 tb/tb_sram_initiator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sram_init_pkg.sv
// Shared encodings for the SRAM request-side initiator: access sizes, write strobes, FSM states.
package sram_init_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} state_t;

  function automatic logic [3:0] strb_of(input logic [1:0] size);
    case (size)
      SZ_B:    strb_of = STRB_B;
      SZ_H:    strb_of = STRB_H;
      default: strb_of = STRB_W;
    endcase
  endfunction

  // Illegal size maps to 1 byte; it is rejected separately.
  function automatic logic [31:0] len_of(input logic [1:0] size);
    case (size)
      SZ_H:    len_of = 32'd2;
      SZ_W:    len_of = 32'd4;
      default: len_of = 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/sram_load_fmt.sv
// Load data formatter: takes the right-aligned SRAM word and returns the byte/half/word
// result sign- or zero-extended to DATA_W bits. Purely combinational.
module sram_load_fmt
  import sram_init_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] result
);

  function automatic logic [DATA_W-1:0] extend(input logic [1:0] sz, input logic uns,
                                               input logic [DATA_W-1:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (sz)
      SZ_B:    extend = uns ? DATA_W'(d[7:0])  : DATA_W'(b);
      SZ_H:    extend = uns ? DATA_W'(d[15:0]) : DATA_W'(h);
      default: extend = d;
    endcase
  endfunction

  assign result = extend(size, is_unsigned, raw);

endmodule

// File: rtl/sram_initiator.sv
// Single-outstanding LSU-to-SRAM initiator: one request in, one SRAM command out, one response back.
// Optional alignment checking is enabled by defining SRAM_INIT_ALIGN_CHECK_EN.
module sram_initiator
  import sram_init_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        read,
  output logic [31:0] r_addr,
  input  logic [31:0] r_data,
  output logic        write,
  output logic [31:0] w_addr,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb
);

  state_t      state, state_nx;
  logic        wr_q, uns_q;
  logic [1:0]  size_q;
  logic        req_err;
  logic [31:0] off, last;
  logic [31:0] fmt_result;

  // Offset arithmetic wraps; a wrapped tail lands below the offset and is rejected.
  always_comb begin
    off     = req_addr - MEM_BASE;
    last    = off + len_of(req_size) - 32'd1;
    req_err = (req_size == SZ_X) || (off >= MEM_SIZE) || (last >= MEM_SIZE) || (last < off);
`ifdef SRAM_INIT_ALIGN_CHECK_EN
    if ((req_size == SZ_H && req_addr[0]) || (req_size == SZ_W && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_err ? RESP : ISSUE;
      end
      ISSUE: begin
        read     = !wr_q;
        write    = wr_q;
        state_nx = wr_q ? RESP : RDATA;
      end
      RDATA: state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  sram_load_fmt u_fmt (
    .size        (size_q),
    .is_unsigned (uns_q),
    .raw         (r_data),
    .result      (fmt_result)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_B;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r_addr     <= '0;
      w_addr     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wr_q       <= req_write;
        uns_q      <= req_unsigned;
        size_q     <= req_size;
        resp_err   <= req_err;
        resp_rdata <= '0;
        if (!req_err) begin
          if (req_write) begin
            w_addr <= req_addr;
            w_data <= req_wdata;
            w_strb <= strb_of(req_size);
          end else begin
            r_addr <= req_addr;
          end
        end
      end
      if (state == RDATA) resp_rdata <= fmt_result;
    end
  end

endmodule

// File: tb/tb_sram_initiator.sv
// Directed and randomized bench for sram_initiator, checked against an arithmetic reference model.
module tb_sram_initiator;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;

  logic        clock, reset_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        read, write;
  logic [31:0] r_addr, r_data, w_addr, w_data;
  logic [3:0]  w_strb;

  int n_cmp = 0;
  int n_bad = 0;

  sram_initiator dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .read(read), .r_addr(r_addr), .r_data(r_data),
    .write(write), .w_addr(w_addr), .w_data(w_data), .w_strb(w_strb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the access [addr, addr+len) must fit inside [BASE, BASE+SIZE).
  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    longint unsigned a, len;
    if (size == 2'b11) return 1'b1;
    len = longint'(1) << size;
    a   = 64'(addr);
    if (a < 64'(BASE) || a + len > 64'(BASE) + 64'(SIZE)) return 1'b1;
`ifdef SRAM_INIT_ALIGN_CHECK_EN
    if (a % len != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] rd);
    longint unsigned m;
    longint v;
    if (size == 2'b10) return rd;
    m = 64'd1 << (8 << size);
    v = longint'(64'(rd) % m);
    if (!uns && 64'(v) >= m / 2) v = v - longint'(m);
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size);
    return 4'((1 << (1 << size)) - 1);
  endfunction

  // Called and returns at posedge+1. hold = cycles resp_ready stays low in RESP;
  // poke presents a competing request during those cycles.
  task automatic do_txn(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int hold, input bit poke);
    bit          e_err;
    logic [31:0] e_rdata;
    e_err   = model_err(size, addr);
    e_rdata = (e_err || wr) ? 32'h0 : model_load(size, uns, rd);
    chk("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    chk("req_ready_busy", 32'(req_ready), 32'h0);
    if (e_err) begin
      chk("err_read", 32'(read), 32'h0);
      chk("err_write", 32'(write), 32'h0);
    end else if (wr) begin
      chk("st_write", 32'(write), 32'h1);
      chk("st_read", 32'(read), 32'h0);
      chk("st_w_addr", w_addr, addr);
      chk("st_w_data", w_data, wdata);
      chk("st_w_strb", 32'(w_strb), 32'(model_strb(size)));
      chk("st_c1_valid", 32'(resp_valid), 32'h0);
      @(posedge clock); #1;
      chk("st_write_off", 32'(write), 32'h0);
    end else begin
      chk("ld_read", 32'(read), 32'h1);
      chk("ld_write", 32'(write), 32'h0);
      chk("ld_r_addr", r_addr, addr);
      r_data = $urandom;
      @(posedge clock); #1;
      chk("ld_read_off", 32'(read), 32'h0);
      chk("ld_c2_valid", 32'(resp_valid), 32'h0);
      r_data = rd;
      @(posedge clock); #1;
      r_data = $urandom;
    end
    chk("resp_valid", 32'(resp_valid), 32'h1);
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rdata);
    for (int i = 0; i < hold; i++) begin
      req_valid = poke; req_write = 1'b0; req_size = 2'b10; req_addr = BASE;
      @(posedge clock); #1;
      chk("hold_valid", 32'(resp_valid), 32'h1);
      chk("hold_err", 32'(resp_err), 32'(e_err));
      chk("hold_rdata", resp_rdata, e_rdata);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      chk("hold_no_cmd", 32'({read, write}), 32'h0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    chk("resp_done", 32'(resp_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0; r_data = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_cmds", 32'({read, write}), 32'h0);
    chk("rst_r_addr", r_addr, 32'h0);
    chk("rst_w_addr", w_addr, 32'h0);
    chk("rst_w_data", w_data, 32'h0);
    chk("rst_w_strb", 32'(w_strb), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'b00, 1'b0, 32'h8000_0013, 32'h0, 32'h0000_00EF, 0, 1'b0);
    do_txn(1'b0, 2'b00, 1'b1, 32'h8000_0013, 32'h0, 32'h0000_00EF, 0, 1'b0);
    do_txn(1'b0, 2'b01, 1'b0, 32'h7FFF_FFFE, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h87FF_FFFE, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'b01, 1'b0, 32'h8000_0100, 32'h0, 32'h1234_8765, 5, 1'b1);
    do_txn(1'b1, 2'b01, 1'b0, 32'h8000_0001, 32'h0000_CAFE, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'b11, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b0, 2'b10, 1'b1, 32'h87FF_FFFC, 32'h0, 32'h89AB_CDEF, 0, 1'b0);

    // Reset during the write cycle of a store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h8000_0040;
    req_wdata = 32'h5555_AAAA;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("mid_write", 32'(write), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_write", 32'(write), 32'h0);
    chk("mid_rst_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h1);
    chk("mid_rst_w_addr", w_addr, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("post_rst_valid", 32'(resp_valid), 32'h0);
      chk("post_rst_ready", 32'(req_ready), 32'h1);
      chk("post_rst_cmds", 32'({read, write}), 32'h0);
    end

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       a = BASE + ($urandom % SIZE);
        1:       a = BASE + SIZE - 32'($urandom_range(0, 5));
        2:       a = BASE - 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      do_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 2), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
